// File: rtl/rr_arb_mux.sv
// Keyed-select / round-robin N:1 arbiter feeding a single-entry registered output stage.
// Channel grant and in_ready are combinational; the output entry and rotation pointer are registered.
module rr_arb_mux #(
  parameter int WIDTH = 2,
  parameter int N_IN  = 4,
  parameter int KEY_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic                  mode,
  input  logic [KEY_W-1:0]      key,
  output logic [WIDTH-1:0]      out_data,
  output logic [KEY_W-1:0]      out_src,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [KEY_W-1:0] ptr;
  logic [KEY_W-1:0] grant;
  logic [KEY_W-1:0] ptr_nxt;
  logic             grant_vld;
  logic             load;
  int               idx;

  assign load = !out_valid || out_ready;

  // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    if (!mode) begin
      if (int'(key) < N_IN) begin
        if (in_valid[key]) begin
          grant     = key;
          grant_vld = 1'b1;
        end
      end
    end else begin
      // Scan offsets from farthest to nearest so the nearest eligible channel after ptr wins.
      for (int k = N_IN - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (in_valid[idx]) begin
          grant     = KEY_W'(idx);
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign ptr_nxt  = (int'(grant) == N_IN - 1) ? '0 : grant + KEY_W'(1);
  assign in_ready = (rst_n && load && grant_vld) ? (N_IN'(1) << grant) : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= grant_vld;
      if (grant_vld) begin
        out_data <= in_data[int'(grant)*WIDTH +: WIDTH];
        out_src  <= grant;
        if (mode) ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: a 4-channel and a 3-channel instance run in lockstep,
// each against its own reference model and scoreboard queue.
module tb_rr_arb_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic [3:0] in_valid;
  logic       mode;
  logic [1:0] key;
  logic       out_ready;

  logic [3:0] rdy4;
  logic [1:0] od4, os4;
  logic       ov4;
  logic [2:0] rdy3;
  logic [1:0] od3, os3;
  logic       ov3;

  int n_vec = 0;
  int n_err = 0;

  logic     m_valid [2];
  int       m_ptr   [2];
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(2), .N_IN(4), .KEY_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
    .mode(mode), .key(key), .out_data(od4), .out_src(os4), .out_valid(ov4), .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(2), .N_IN(3), .KEY_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[5:0]), .in_valid(in_valid[2:0]), .in_ready(rdy3),
    .mode(mode), .key(key), .out_data(od3), .out_src(os3), .out_valid(ov3), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 1'b0;
      m_ptr[u]   = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst rdy4", 32'(rdy4), 0);
    check("rst ov4",  32'(ov4),  0);
    check("rst od4",  32'(od4),  0);
    check("rst os4",  32'(os4),  0);
    check("rst ptr4", 32'(dut4.ptr), 0);
    check("rst rdy3", 32'(rdy3), 0);
    check("rst ov3",  32'(ov3),  0);
    check("rst od3",  32'(od3),  0);
    check("rst ptr3", 32'(dut3.ptr), 0);
  endtask

  // One clock cycle: drive inputs, check combinational handshake and consumed entries, advance models.
  task automatic step(input logic m, input logic [1:0] k, input logic [3:0] v,
                      input logic [7:0] d, input logic ordy);
    logic [3:0] vm, exp_rdy, act_rdy, ent;
    logic       found, ld, act_ov;
    logic [1:0] act_od, act_os;
    int         n, g, p;
    mode = m; key = k; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    for (int u = 0; u < 2; u++) begin
      n       = (u == 0) ? 4 : 3;
      vm      = (u == 0) ? v : {1'b0, v[2:0]};
      act_rdy = (u == 0) ? rdy4 : {1'b0, rdy3};
      act_ov  = (u == 0) ? ov4 : ov3;
      act_od  = (u == 0) ? od4 : od3;
      act_os  = (u == 0) ? os4 : os3;
      found = 1'b0;
      g     = 0;
      if (!m) begin
        if (int'(k) < n && vm[k]) begin
          found = 1'b1;
          g     = int'(k);
        end
      end else begin
        for (int j = 0; j < n && !found; j++) begin
          p = (m_ptr[u] + j) % n;
          if (vm[p]) begin
            found = 1'b1;
            g     = p;
          end
        end
      end
      ld      = !m_valid[u] || ordy;
      exp_rdy = (ld && found) ? 4'(1 << g) : 4'b0;
      check((u == 0) ? "in_ready n4" : "in_ready n3", 32'(act_rdy), 32'(exp_rdy));
      check((u == 0) ? "out_valid n4" : "out_valid n3", 32'(act_ov), 32'(m_valid[u]));
      if (m_valid[u] && ordy) begin
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
          check("scoreboard underflow", 1, 0);
        end else begin
          ent = (u == 0) ? q0.pop_front() : q1.pop_front();
          check((u == 0) ? "out_src n4" : "out_src n3", 32'(act_os), 32'(ent[3:2]));
          check((u == 0) ? "out_data n4" : "out_data n3", 32'(act_od), 32'(ent[1:0]));
        end
      end
      if (ld) begin
        m_valid[u] = found;
        if (found) begin
          ent = {2'(g), d[g*2 +: 2]};
          if (u == 0) q0.push_back(ent);
          else        q1.push_back(ent);
          if (m) m_ptr[u] = (g + 1) % n;
        end
      end
    end
    @(posedge clk);
    #1;
    check("ptr n4", 32'(dut4.ptr), 32'(m_ptr[0]));
    check("ptr n3", 32'(dut3.ptr), 32'(m_ptr[1]));
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; key = 2'd0; in_valid = 4'b1111; in_data = 8'hff; out_ready = 1'b1;
    model_reset();
    #1;
    check_reset_outputs();
    #11;
    rst_n = 1'b1;

    // Keyed select of channel 2 (ch2 = 2'b10); pointer must not move.
    step(1'b0, 2'd2, 4'b1111, 8'b00_10_00_00, 1'b1);
    step(1'b0, 2'd2, 4'b0000, 8'h00, 1'b1);

    // Round-robin with all requesting: one transfer per cycle, rotating sources.
    for (int i = 0; i < 6; i++) step(1'b1, 2'd0, 4'b1111, 8'($urandom), 1'b1);
    step(1'b1, 2'd0, 4'b0000, 8'h00, 1'b1);

    // Move n4 pointer to 3, then wrap to channel 0 and continue with channel 1.
    step(1'b1, 2'd0, 4'b0100, 8'($urandom), 1'b1);
    step(1'b1, 2'd0, 4'b0011, 8'($urandom), 1'b1);
    step(1'b1, 2'd0, 4'b0011, 8'($urandom), 1'b1);

    // Backpressure for three cycles, then drain and refill on the same edge.
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 4'b1111, 8'($urandom), 1'b0);
    step(1'b1, 2'd0, 4'b1111, 8'($urandom), 1'b1);
    step(1'b1, 2'd0, 4'b1111, 8'($urandom), 1'b1);

    // Key beyond the 3-channel instance: nothing eligible there, output drains.
    for (int i = 0; i < 3; i++) step(1'b0, 2'd3, 4'b1111, 8'($urandom), 1'b1);

    // Round-robin cycling on the 3-channel instance: ptr must stay within 0..2.
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 4'b0111, 8'($urandom), 1'b1);

    // Mixed random traffic with occasional backpressure and mode/key changes.
    for (int i = 0; i < 60; i++)
      step(1'($urandom), 2'($urandom), 4'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));

    // Load an entry holding 2'b11, then drop reset between edges.
    step(1'b0, 2'd0, 4'b1111, 8'hff, 1'b1);
    step(1'b0, 2'd0, 4'b1111, 8'hff, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs();
    #2;
    rst_n = 1'b1;

    // First grant must land on the first edge after release.
    step(1'b1, 2'd0, 4'b1010, 8'($urandom), 1'b1);
    step(1'b1, 2'd0, 4'b0000, 8'h00, 1'b1);
    step(1'b1, 2'd0, 4'b0000, 8'h00, 1'b1);
    check("leftover n4", 32'(q0.size()), 0);
    check("leftover n3", 32'(q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the data bits per channel.
REQ-002 Parameter N_IN, default 4, SHALL set the input channel count, range 2..16.
REQ-003 Parameter KEY_W, default 2, SHALL set the width of key and out_src; 2^KEY_W >= N_IN SHALL hold.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 in_data  input  N_IN*WIDTH  SHALL carry channel i in bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N_IN  SHALL flag channel i as offering data.
REQ-008 in_ready  output  N_IN  SHALL be high for channel i only in the cycle its data is accepted.
REQ-009 mode  input  1  SHALL select 0 = keyed select, 1 = round-robin arbitration.
REQ-010 key  input  KEY_W  SHALL be the channel index used in mode 0.
REQ-011 out_data  output  WIDTH  SHALL be the registered selected data.
REQ-012 out_src  output  KEY_W  SHALL be the registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  SHALL flag out_data/out_src as holding an entry.
REQ-014 out_ready  input  1  SHALL be the downstream consumer's acceptance signal.

Function
REQ-015 The output stage SHALL be one register entry; load = (!out_valid) | out_ready.
REQ-016 Eligible set, mode 0: channel key only, when key < N_IN and in_valid[key]; key >= N_IN SHALL make no channel eligible.
REQ-017 Eligible set, mode 1: every i with in_valid[i]; grant SHALL be the first eligible index found searching upward from ptr, wrapping N_IN-1 -> 0.
REQ-018 At most one in_ready bit SHALL be high per cycle: in_ready[g] = load & a grant g exists.
REQ-019 in_ready SHALL be combinational from in_valid, mode, key, ptr, out_valid, out_ready; no input SHALL wait on in_ready before asserting in_valid.
REQ-020 On a grant g: out_data <= channel g data, out_src <= g, out_valid <= 1, next edge; latency in_valid -> out_valid is exactly 1 cycle.
REQ-021 load with no grant SHALL set out_valid <= 0; out_data and out_src SHALL hold their previous values.
REQ-022 !load (out_valid & !out_ready) SHALL hold out_data, out_src and out_valid stable; all in_ready SHALL be 0.
REQ-023 Simultaneous drain and fill (out_valid & out_ready & grant) SHALL replace the entry in the same edge with no bubble; full throughput is 1 transfer/cycle.
REQ-024 Pointer ptr (KEY_W bits) SHALL update to (g+1) mod N_IN only on a mode-1 grant; mode-0 grants and idle cycles SHALL leave ptr unchanged.
REQ-025 A mode or key change SHALL take effect in the same cycle's arbitration; an entry already in the output register SHALL be unaffected.
REQ-026 With N_IN not a power of two, ptr SHALL never take a value >= N_IN.

Reset
REQ-027 rst_n low SHALL immediately force out_valid=0, out_data=0, out_src=0, ptr=0 regardless of clk.
REQ-028 During reset all in_ready SHALL be 0; an accept in progress SHALL be discarded.
REQ-029 After rst_n rises, the first grant SHALL be possible on the first rising clk edge.

Verification
REQ-030 Reset mid-transfer: out_valid=1, out_data=2'b11, drop rst_n between edges -> out_valid=0, out_data=0, out_src=0 before next edge.
REQ-031 Mode 0, key=2, in_valid=4'b1111, ch2=2'b10, out_ready=1 -> in_ready=4'b0100; next cycle out_data=2'b10, out_src=2, ptr unchanged at 0.
REQ-032 Mode 1, in_valid=4'b1111 held, out_ready=1 for 5 cycles -> out_src sequence 0,1,2,3,0, one transfer per cycle, no gaps.
REQ-033 Mode 1, ptr=3, in_valid=4'b0011 -> grant 0 (wrap), then ptr=1, next grant 1.
REQ-034 Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b1111 -> in_ready=0, out_data/out_src stable; out_ready=1 -> drain and refill same edge.
REQ-035 N_IN=3, KEY_W=2, mode 0, key=3 -> no in_ready, out_valid falls to 0 after drain; mode 1 cycle shows ptr sequence 1,2,0 only.
